instruction_prefetch: RTL and testbench
=======================================

INSTRUCTION_PREFETCH -- requirements
Module: instruction_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the prefetch FIFO entry count; legal values are powers of two from 2 to 16.
REQ-002 Parameter RESET_PC, default 12'h000, SHALL set the first fetch address after reset.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-005 imem_addr  out  12  SHALL carry the instruction address and drive the memory Instruction_addressbus.
REQ-006 imem_data  in  16  SHALL carry the instruction word from the memory Instruction_databus.
REQ-007 instr  out  16  SHALL present the FIFO head instruction to the BU2020 decode stage.
REQ-008 instr_pc  out  12  SHALL present the byte address of instr.
REQ-009 instr_valid  out  1  SHALL be high when instr/instr_pc hold a valid entry.
REQ-010 instr_ready  in  1  SHALL be high when the consumer accepts the head entry this cycle.
REQ-011 redirect  in  1  SHALL request a flush and a refetch from redirect_pc (branch/jump).
REQ-012 redirect_pc  in  12  SHALL carry the new fetch address; bit 0 is ignored and treated as 0.

Function
REQ-013 Memory timing: imem_data SHALL be sampled one cycle after imem_addr was presented (one-cycle read latency, one outstanding fetch).
REQ-014 fetch_pc SHALL advance by 2 per issued fetch; 12'hFFE + 2 SHALL wrap to 12'h000.
REQ-015 A fetch SHALL issue only when occupancy + in-flight < DEPTH; otherwise imem_addr SHALL hold its value.
REQ-016 A returned word SHALL be written to the FIFO tail together with its address.
REQ-017 With a non-full FIFO and instr_ready held high, throughput SHALL be one instruction per cycle after a 2-cycle initial latency (issue, return, visible).
REQ-018 A pop SHALL occur on instr_valid && instr_ready; instr, instr_pc and instr_valid SHALL be unchanged while instr_valid && !instr_ready.
REQ-019 A simultaneous push and pop SHALL leave occupancy unchanged; pop from empty and push to full SHALL never occur.
REQ-020 FSM states: FILL (fetching, FIFO not full), HOLD (FIFO plus in-flight full, no issue) and REDIR (one-cycle flush); FILL<->HOLD follow REQ-015; any state goes to REDIR on redirect; REDIR goes to FILL.
REQ-021 On redirect: FIFO emptied, in-flight response discarded, instr_valid low the next cycle, fetch_pc loaded with redirect_pc, first refetch issued in the REDIR cycle.
REQ-022 A handshake in the same cycle as redirect SHALL count as accepted; redirect takes priority over every push.
REQ-023 A redirect asserted in REDIR SHALL restart REDIR with the newer redirect_pc.

Reset
REQ-024 While reset is high: FIFO empty, instr_valid=0, instr=16'h0000, instr_pc=12'h000, imem_addr=RESET_PC, in-flight cleared, FSM=FILL.
REQ-025 The first fetch SHALL issue in the first cycle after reset deasserts.
REQ-026 Reset asserted mid-operation SHALL discard all queued and in-flight words, and no stale word SHALL appear after release.

Configuration
REQ-027 With PREFETCH_STATS_EN defined: extra outputs fetch_count (out, 16) and flush_count (out, 16), cleared by reset and saturating at 16'hFFFF, counting issued fetches and redirects.
REQ-028 Without PREFETCH_STATS_EN: those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Memory holds 16'h1111/2222/3333 at 0x000/0x002/0x004, instr_ready=1 after reset -> instr_valid high from cycle 2, with instr_pc 0x000, 0x002, 0x004 on consecutive cycles.
REQ-030 instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 entries queued (PCs 0x000-0x006), imem_addr holds at 0x008, and the head is stable.
REQ-031 Redirect to 0x100 with 3 entries queued -> instr_valid low next cycle, and the next valid instr_pc is 0x100 with no 0x00x PC reappearing.
REQ-032 Redirect to 0xFFC, instr_ready=1 -> instr_pc sequence 0xFFC, 0xFFE, 0x000.
REQ-033 Reset pulsed for 1 cycle while full and fetch in flight -> post-reset instr_pc sequence starts at RESET_PC, with no stale data.
REQ-034 PREFETCH_STATS_EN defined, 5 fetches then 2 redirects -> flush_count=2 and fetch_count equal to the number of issued fetches.

Source files
------------

// File: rtl/instruction_prefetch.sv
// Instruction prefetch FIFO between a one-cycle-latency instruction memory and decode.
// Define PREFETCH_STATS_EN to add the saturating fetch_count/flush_count outputs.
module instruction_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [11:0] redirect_pc
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0] fetch_count,
    output logic [15:0] flush_count
`endif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {FILL, HOLD, REDIR} state_e;

    state_e        state_q, state_d;
    logic [11:0]   addr_q, addr_d;
    logic          infl_q, infl_d;
    logic [11:0]   infl_pc_q, infl_pc_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   data_q [DEPTH];
    logic [15:0]   data_d [DEPTH];
    logic [11:0]   pc_q [DEPTH];
    logic [11:0]   pc_d [DEPTH];
    logic          issue;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[0];

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        infl_pc_d = addr_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        data_d    = data_q;
        pc_d      = pc_q;
        pop       = (cnt_q != '0) && instr_ready;
        // The redirect cycle issues nothing; its response would be discarded anyway.
        issue     = (state_q != HOLD) && !redirect;
        push      = infl_q && !redirect;
        infl_d    = issue;
        if (issue) begin
            addr_d = addr_q + 12'd2;
        end
        if (push) begin
            data_d[wr_q] = imem_data;
            pc_d[wr_q]   = infl_pc_q;
            wr_d         = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (redirect) begin
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
            addr_d  = {redirect_pc[11:1], 1'b0};
            state_d = REDIR;
        end else if ((cnt_d + CW'(infl_d)) < DEPTH_C) begin
            state_d = FILL;
        end else begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            addr_q    <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        pc_q   <= pc_d;
    end

    assign imem_addr   = addr_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = instr_valid ? data_q[rd_q] : 16'h0000;
    assign instr_pc    = instr_valid ? pc_q[rd_q] : 12'h000;

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_count_q, fetch_count_d;
    logic [15:0] flush_count_q, flush_count_d;

    always_comb begin
        fetch_count_d = fetch_count_q;
        flush_count_d = flush_count_q;
        if (issue && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
        if (redirect && (flush_count_q != 16'hFFFF)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_instruction_prefetch.sv
// Scoreboard bench for instruction_prefetch: expected PC stream model vs. handshakes,
// plus directed latency, stall, redirect, wrap and reset scenarios.
module tb_instruction_prefetch;
    localparam int unsigned DEPTH    = 4;
    localparam logic [11:0] RESET_PC = 12'h000;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [11:0] redirect_pc;
`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_count;
    logic [15:0] flush_count;
`endif

    instruction_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
`ifdef PREFETCH_STATS_EN
        ,
        .fetch_count(fetch_count),
        .flush_count(flush_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] mem [2048];
    always @(posedge clk) imem_data <= mem[imem_addr[11:1]];

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int stall = 0;
    int redirs = 0;

    logic [11:0] exp_q [$];
    logic [11:0] gen_pc;
    logic        prev_red = 1'b0;
    logic        prev_rst = 1'b0;
    logic        hold_pend = 1'b0;
    logic [11:0] hold_pc;
    logic [15:0] hold_instr;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    function automatic void model_restart(logic [11:0] pc);
        exp_q.delete();
        gen_pc = pc;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(gen_pc);
            gen_pc += 12'd2;
        end
    endfunction

    // Monitor: reference model is "consecutive PCs from the last restart point".
    always @(negedge clk) begin
        logic [11:0] e;
        if (reset) begin
            model_restart(RESET_PC);
            prev_red  = 1'b0;
            hold_pend = 1'b0;
            prev_rst  = 1'b1;
            stall     = 0;
            redirs    = 0;
        end else begin
            if (prev_rst) begin
                chk("post_reset_valid", 32'(instr_valid), 32'd0);
                chk("post_reset_addr", 32'(imem_addr), 32'(RESET_PC));
            end
            if (prev_red) begin
                chk("redirect_flush_valid", 32'(instr_valid), 32'd0);
            end
            if (hold_pend) begin
                chk("hold_valid", 32'(instr_valid), 32'd1);
                chk("hold_pc", 32'(instr_pc), 32'(hold_pc));
                chk("hold_instr", 32'(instr), 32'(hold_instr));
            end
            if (instr_valid && instr_ready) begin
                e = exp_q.pop_front();
                exp_q.push_back(gen_pc);
                gen_pc += 12'd2;
                chk("sb_pc", 32'(instr_pc), 32'(e));
                chk("sb_instr", 32'(instr), 32'(mem[e[11:1]]));
                hs_count++;
            end
            if (instr_ready && !instr_valid && !redirect) begin
                stall++;
            end else begin
                stall = 0;
            end
            if (stall > 4) begin
                checks++;
                errors++;
                $display("FAIL liveness: got %0d idle cycles expected at most 4", stall);
                stall = 0;
            end
            if (redirect) begin
                model_restart({redirect_pc[11:1], 1'b0});
                redirs++;
            end
            hold_pend  = instr_valid && !instr_ready && !redirect;
            hold_pc    = instr_pc;
            hold_instr = instr;
            prev_red   = redirect;
            prev_rst   = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1111;
        mem[1] = 16'h2222;
        mem[2] = 16'h3333;
        reset       = 1'b1;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_instr", 32'(instr), 32'h0);
        chk("reset_pc", 32'(instr_pc), 32'h0);
        chk("reset_addr", 32'(imem_addr), 32'(RESET_PC));

        // initial latency and back-to-back delivery
        step();
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("lat_c0_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("lat_c1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", 32'(instr_valid), 32'd1);
        chk("lat_c2_pc", 32'(instr_pc), 32'h000);
        chk("lat_c2_instr", 32'(instr), 32'h1111);
        @(negedge clk);
        chk("lat_c3_pc", 32'(instr_pc), 32'h002);
        chk("lat_c3_instr", 32'(instr), 32'h2222);
        @(negedge clk);
        chk("lat_c4_pc", 32'(instr_pc), 32'h004);
        chk("lat_c4_instr", 32'(instr), 32'h3333);

        // consumer stalled: FIFO fills to DEPTH and fetch stops
        step();
        reset       = 1'b1;
        instr_ready = 1'b0;
        step();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("full_addr_hold", 32'(imem_addr), 32'h008);
        chk("full_head_valid", 32'(instr_valid), 32'd1);
        chk("full_head_pc", 32'(instr_pc), 32'h000);
        step();
        instr_ready = 1'b1;
        repeat (6) step();

        // redirect with entries queued
        instr_ready = 1'b0;
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 12'h100;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("redir_valid_low", 32'(instr_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("redir_first_pc", 32'(instr_pc), 32'h100);
        repeat (6) step();

        // wrap past the top of the address space
        redirect    = 1'b1;
        redirect_pc = 12'hFFC;
        step();
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("wrap_pc0", 32'(instr_pc), 32'hFFC);
        @(negedge clk);
        chk("wrap_pc1", 32'(instr_pc), 32'hFFE);
        @(negedge clk);
        chk("wrap_pc2", 32'(instr_pc), 32'h000);
        step();

        // back-to-back redirects: the newer target wins, odd bit ignored
        redirect    = 1'b1;
        redirect_pc = 12'h200;
        step();
        redirect_pc = 12'h301;
        step();
        redirect = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("reredir_pc", 32'(instr_pc), 32'h300);
        step();

        // reset pulse while full with a fetch in flight
        instr_ready = 1'b0;
        repeat (4) step();
        reset = 1'b1;
        step();
        reset       = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pulse_valid", 32'(instr_valid), 32'd1);
        chk("rst_pulse_pc", 32'(instr_pc), 32'(RESET_PC));
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = 12'($urandom);
            reset       = ($urandom_range(0, 399) == 0);
            step();
        end
        reset       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("handshakes_seen", 32'(hs_count > 500), 32'd1);
`ifdef PREFETCH_STATS_EN
        chk("flush_count", 32'(flush_count), 32'(redirs));
        chk("fetch_count_nonzero", 32'(fetch_count != 16'h0), 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
